// File: rtl/inst_aligner_if.sv
// ---------------------------------------------------------------------------
// inst_aligner_if
// Bundles the fetch-side, redirect and instruction-side signals of the
// instruction aligner.
//
// Signals:
//   fetch_valid  fetch word present
//   fetch_ready  aligner accepts the fetch word this cycle
//   fetch_data   32-bit little-endian fetch word
//   fetch_pc     word address of fetch_data (bits [1:0] ignored)
//   redirect     flush-and-restart pulse
//   redirect_pc  restart address (only bit 1 is meaningful)
//   inst_valid   registered instruction available
//   inst_ready   downstream consumes inst_* this cycle
//   inst_data    raw instruction (compressed forms zero-extended)
//   inst_pc      address of inst_data
//   inst_is_comp inst_data is a 16-bit instruction
//
// Modports:
//   slave  - the aligner itself
//   master - the environment (fetch unit / decoder side)
// ---------------------------------------------------------------------------
interface inst_aligner_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [31:0] fetch_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_is_comp;

    modport slave (
        input  fetch_valid,
        input  fetch_data,
        input  fetch_pc,
        input  redirect,
        input  redirect_pc,
        input  inst_ready,
        output fetch_ready,
        output inst_valid,
        output inst_data,
        output inst_pc,
        output inst_is_comp
    );

    modport master (
        output fetch_valid,
        output fetch_data,
        output fetch_pc,
        output redirect,
        output redirect_pc,
        output inst_ready,
        input  fetch_ready,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        input  inst_is_comp
    );
endinterface

// File: rtl/inst_aligner.sv
// ---------------------------------------------------------------------------
// inst_aligner
// Turns a stream of 32-bit fetch words into a stream of individual
// instructions with their addresses. With compressed support enabled, a word
// may hold two 16-bit instructions, or a 32-bit instruction may straddle two
// fetch words; a single halfword is buffered to stitch those together.
// The output slot is a single register stage (1-cycle latency).
//
// Configuration macro: RVC_ALIGN_EN
//   defined   - full compressed-instruction alignment (ALIGNED/HOLD/SKIP)
//   undefined - registered 32-bit word pass-through, redirect_pc ignored
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    inst_aligner_if.slave (fetch, redirect and instruction signals)
// ---------------------------------------------------------------------------
module inst_aligner (
    input  logic          clk,
    input  logic          reset,
    inst_aligner_if.slave bus
);

    // Output slot registers
    logic        r_inst_valid;
    logic [31:0] r_inst_data;
    logic [31:0] r_inst_pc;
    logic        r_inst_comp;

    // Next-state values for the output slot
    logic        w_inst_valid_n;
    logic [31:0] w_inst_data_n;
    logic [31:0] w_inst_pc_n;
    logic        w_inst_comp_n;

    logic        w_slot_free;
    logic        w_fetch_ready;
    logic        w_accept;
    logic [31:0] w_fetch_pc_al;

    // The slot can take a new instruction when empty or being drained now.
    assign w_slot_free   = !r_inst_valid || bus.inst_ready;
    assign w_fetch_pc_al = {bus.fetch_pc[31:2], 2'b00};
    assign w_accept      = bus.fetch_valid && w_fetch_ready;

`ifdef RVC_ALIGN_EN

    typedef enum logic [1:0] {
        ALIGNED = 2'd0,
        HOLD    = 2'd1,
        SKIP    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [15:0] r_hold_hw;
    logic [15:0] w_hold_hw_n;
    logic [31:0] r_hold_pc;
    logic [31:0] w_hold_pc_n;

    logic        w_hold_comp;
    logic [15:0] w_lo;
    logic [15:0] w_hi;
    logic [31:0] w_hi_pc;

    assign w_hold_comp = (r_hold_hw[1:0] != 2'b11);
    assign w_lo        = bus.fetch_data[15:0];
    assign w_hi        = bus.fetch_data[31:16];
    assign w_hi_pc     = w_fetch_pc_al + 32'd2;

    // A held compressed instruction is emitted on its own, so no fetch word
    // may be taken in that cycle. Reset gating keeps fetch_ready low while
    // reset is asserted.
    assign w_fetch_ready = !reset && !bus.redirect && w_slot_free &&
                           !((r_state == HOLD) && w_hold_comp);

    always_comb begin
        w_state_n      = r_state;
        w_hold_hw_n    = r_hold_hw;
        w_hold_pc_n    = r_hold_pc;
        w_inst_valid_n = w_slot_free ? 1'b0 : r_inst_valid;
        w_inst_data_n  = r_inst_data;
        w_inst_pc_n    = r_inst_pc;
        w_inst_comp_n  = r_inst_comp;

        if (bus.redirect) begin
            // Redirect wins over everything, including a pending output.
            w_inst_valid_n = 1'b0;
            w_hold_hw_n    = '0;
            w_hold_pc_n    = '0;
            w_state_n      = bus.redirect_pc[1] ? SKIP : ALIGNED;
        end else begin
            case (r_state)
                ALIGNED: begin
                    if (w_accept) begin
                        w_inst_valid_n = 1'b1;
                        w_inst_pc_n    = w_fetch_pc_al;
                        if (w_lo[1:0] == 2'b11) begin
                            w_inst_data_n = bus.fetch_data;
                            w_inst_comp_n = 1'b0;
                        end else begin
                            w_inst_data_n = {16'h0000, w_lo};
                            w_inst_comp_n = 1'b1;
                            w_hold_hw_n   = w_hi;
                            w_hold_pc_n   = w_hi_pc;
                            w_state_n     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_hold_comp) begin
                        if (w_slot_free) begin
                            w_inst_valid_n = 1'b1;
                            w_inst_data_n  = {16'h0000, r_hold_hw};
                            w_inst_pc_n    = r_hold_pc;
                            w_inst_comp_n  = 1'b1;
                            w_state_n      = ALIGNED;
                        end
                    end else if (w_accept) begin
                        // Straddling 32-bit instruction completes with the
                        // low half of the new word; its high half is held.
                        w_inst_valid_n = 1'b1;
                        w_inst_data_n  = {w_lo, r_hold_hw};
                        w_inst_pc_n    = r_hold_pc;
                        w_inst_comp_n  = 1'b0;
                        w_hold_hw_n    = w_hi;
                        w_hold_pc_n    = w_hi_pc;
                    end
                end
                SKIP: begin
                    if (w_accept) begin
                        w_hold_hw_n = w_hi;
                        w_hold_pc_n = w_hi_pc;
                        w_state_n   = HOLD;
                    end
                end
                default: begin
                    w_state_n = ALIGNED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ALIGNED;
            r_hold_hw <= '0;
            r_hold_pc <= '0;
        end else begin
            r_state   <= w_state_n;
            r_hold_hw <= w_hold_hw_n;
            r_hold_pc <= w_hold_pc_n;
        end
    end

`else

    assign w_fetch_ready = !reset && !bus.redirect && w_slot_free;

    always_comb begin
        w_inst_valid_n = w_slot_free ? 1'b0 : r_inst_valid;
        w_inst_data_n  = r_inst_data;
        w_inst_pc_n    = r_inst_pc;
        w_inst_comp_n  = 1'b0;

        if (bus.redirect) begin
            w_inst_valid_n = 1'b0;
        end else if (w_accept) begin
            w_inst_valid_n = 1'b1;
            w_inst_data_n  = bus.fetch_data;
            w_inst_pc_n    = w_fetch_pc_al;
        end
    end

`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= '0;
            r_inst_comp  <= 1'b0;
        end else begin
            r_inst_valid <= w_inst_valid_n;
            r_inst_data  <= w_inst_data_n;
            r_inst_pc    <= w_inst_pc_n;
            r_inst_comp  <= w_inst_comp_n;
        end
    end

    assign bus.fetch_ready  = w_fetch_ready;
    assign bus.inst_valid   = r_inst_valid;
    assign bus.inst_data    = r_inst_data;
    assign bus.inst_pc      = r_inst_pc;
    assign bus.inst_is_comp = r_inst_comp;

endmodule

// File: tb/tb_inst_aligner.sv
// ---------------------------------------------------------------------------
// tb_inst_aligner
// Directed, table-driven bench for inst_aligner. Each table record holds the
// inputs for one cycle, the expected combinational fetch_ready in that cycle
// and the expected registered inst_* after the following rising edge.
// Expectations for the compressed build are selected with RVC_ALIGN_EN.
// ---------------------------------------------------------------------------
module tb_inst_aligner;

    logic clk;
    logic reset;

    inst_aligner_if bus ();

    inst_aligner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] fd;
        logic [31:0] fpc;
        logic        rd;
        logic [31:0] rpc;
        logic        ir;
        logic        efr;
        logic        ev;
        logic [31:0] ed;
        logic [31:0] epc;
        logic        ec;
    } vec_t;

    vec_t vt[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(logic fv, logic [31:0] fd, logic [31:0] fpc,
                                logic rd, logic [31:0] rpc, logic ir,
                                logic efr, logic ev, logic [31:0] ed,
                                logic [31:0] epc, logic ec);
        vec_t v;
        v.fv = fv; v.fd = fd; v.fpc = fpc; v.rd = rd; v.rpc = rpc; v.ir = ir;
        v.efr = efr; v.ev = ev; v.ed = ed; v.epc = epc; v.ec = ec;
        return v;
    endfunction

    task automatic drive(vec_t v);
        bus.fetch_valid = v.fv;
        bus.fetch_data  = v.fd;
        bus.fetch_pc    = v.fpc;
        bus.redirect    = v.rd;
        bus.redirect_pc = v.rpc;
        bus.inst_ready  = v.ir;
    endtask

    task automatic chk_fr(string name, logic exp);
        n_vec++;
        if (bus.fetch_ready !== exp) begin
            n_bad++;
            $display("FAIL %s fetch_ready: got %b want %b", name, bus.fetch_ready, exp);
        end
    endtask

    // Payload fields are compared only when a valid instruction is expected.
    task automatic chk_out(string name, logic ev, logic [31:0] ed,
                           logic [31:0] epc, logic ec);
        logic bad;
        n_vec++;
        bad = (bus.inst_valid !== ev);
        if (ev && ((bus.inst_data !== ed) || (bus.inst_pc !== epc) ||
                   (bus.inst_is_comp !== ec)))
            bad = 1'b1;
        if (bad) begin
            n_bad++;
            $display("FAIL %s inst: got v=%b d=%h pc=%h c=%b want v=%b d=%h pc=%h c=%b",
                     name, bus.inst_valid, bus.inst_data, bus.inst_pc,
                     bus.inst_is_comp, ev, ed, epc, ec);
        end
    endtask

    task automatic chk_reset_state(string name);
        n_vec++;
        if ((bus.inst_valid !== 1'b0) || (bus.inst_data !== 32'h0) ||
            (bus.inst_pc !== 32'h0) || (bus.inst_is_comp !== 1'b0) ||
            (bus.fetch_ready !== 1'b0)) begin
            n_bad++;
            $display("FAIL %s: got v=%b d=%h pc=%h c=%b fr=%b want all zero",
                     name, bus.inst_valid, bus.inst_data, bus.inst_pc,
                     bus.inst_is_comp, bus.fetch_ready);
        end
    endtask

    task automatic apply(string name, vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk_fr(name, v.efr);
        @(posedge clk);
        #1;
        chk_out(name, v.ev, v.ed, v.epc, v.ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;

`ifdef RVC_ALIGN_EN
        // two compressed in one word
        vt.push_back(mk(1, 32'h45054501, 32'h100, 0, 0, 1, 1, 1, 32'h4501, 32'h100, 1));
        vt.push_back(mk(1, 32'h00000013, 32'h104, 0, 0, 1, 0, 1, 32'h4505, 32'h102, 1));
        // straddling 32-bit instruction
        vt.push_back(mk(1, 32'h05134501, 32'h200, 0, 0, 1, 1, 1, 32'h4501, 32'h200, 1));
        vt.push_back(mk(1, 32'h45850085, 32'h204, 0, 0, 1, 1, 1, 32'h00850513, 32'h202, 0));
        vt.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 32'h4585, 32'h206, 1));
        vt.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        // redirect to odd halfword: low half skipped
        vt.push_back(mk(1, 32'hDEADBEEF, 32'h0, 1, 32'h302, 1, 0, 0, 32'h0, 32'h0, 0));
        vt.push_back(mk(1, 32'h0001FFFF, 32'h300, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vt.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 32'h0001, 32'h302, 1));
        // redirect while a 32-bit upper half is held
        vt.push_back(mk(1, 32'h00034501, 32'h400, 0, 0, 1, 1, 1, 32'h4501, 32'h400, 1));
        vt.push_back(mk(1, 32'h11111111, 32'h404, 1, 32'h500, 1, 0, 0, 32'h0, 32'h0, 0));
        vt.push_back(mk(1, 32'h00000013, 32'h500, 0, 0, 1, 1, 1, 32'h00000013, 32'h500, 0));
        // back-pressure for 5 cycles
        vt.push_back(mk(1, 32'h45054501, 32'h600, 0, 0, 1, 1, 1, 32'h4501, 32'h600, 1));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(1, 32'h11111111, 32'h604, 0, 0, 0, 0, 1, 32'h4501, 32'h600, 1));
        vt.push_back(mk(1, 32'h11111111, 32'h604, 0, 0, 1, 0, 1, 32'h4505, 32'h602, 1));
        vt.push_back(mk(1, 32'h00A00093, 32'h604, 0, 0, 1, 1, 1, 32'h00A00093, 32'h604, 0));
        // straddle across the 2^32 wrap
        vt.push_back(mk(1, 32'h05134501, 32'hFFFFFFFC, 0, 0, 1, 1, 1, 32'h4501, 32'hFFFFFFFC, 1));
        vt.push_back(mk(1, 32'h00010085, 32'h0, 0, 0, 1, 1, 1, 32'h00850513, 32'hFFFFFFFE, 0));
        vt.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 32'h0001, 32'h00000002, 1));
        vt.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0));
`else
        vt.push_back(mk(1, 32'h45054501, 32'h100, 0, 0, 1, 1, 1, 32'h45054501, 32'h100, 0));
        vt.push_back(mk(1, 32'h00850513, 32'h104, 0, 0, 0, 0, 1, 32'h45054501, 32'h100, 0));
        vt.push_back(mk(1, 32'h00850513, 32'h104, 0, 0, 0, 0, 1, 32'h45054501, 32'h100, 0));
        vt.push_back(mk(1, 32'h00850513, 32'h104, 0, 0, 1, 1, 1, 32'h00850513, 32'h104, 0));
        vt.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        vt.push_back(mk(1, 32'hAAAA5555, 32'h200, 1, 32'h202, 1, 0, 0, 32'h0, 32'h0, 0));
        vt.push_back(mk(1, 32'hDEADBEEF, 32'hFFFFFFFC, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'hFFFFFFFC, 0));
        vt.push_back(mk(1, 32'h11111111, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0));
        vt.push_back(mk(1, 32'h12345678, 32'h300, 0, 32'h302, 0, 1, 1, 32'h12345678, 32'h300, 0));
        vt.push_back(mk(1, 32'h00000001, 32'h304, 0, 0, 1, 1, 1, 32'h00000001, 32'h304, 0));
`endif

        // Reset with active-looking inputs: everything must stay at zero.
        reset = 1'b1;
        drive(mk(1, 32'h45054501, 32'h100, 0, 0, 1, 0, 0, 0, 0, 0));
        #1;
        chk_reset_state("reset_t0");
        @(posedge clk);
        #1;
        chk_reset_state("reset_edge");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++)
            apply($sformatf("vec%0d", i), vt[i]);

        // Asynchronous reset in the middle of a straddle.
`ifdef RVC_ALIGN_EN
        apply("mid_first", mk(1, 32'h05134501, 32'h700, 0, 0, 1, 1, 1, 32'h4501, 32'h700, 1));
`else
        apply("mid_first", mk(1, 32'h05134501, 32'h700, 0, 0, 1, 1, 1, 32'h05134501, 32'h700, 0));
`endif
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("async_reset");
        @(posedge clk);
        #1;
        chk_reset_state("async_reset_edge");
        @(negedge clk);
        reset = 1'b0;
        apply("post_reset", mk(1, 32'h00000013, 32'h704, 0, 0, 1, 1, 1, 32'h00000013, 32'h704, 0));
        apply("post_reset_idle", mk(0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 32'h0, 32'h0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
